sd_cmd_controller: RTL and testbench

SD_CMD_CONTROLLER -- requirements
Module: sd_cmd_controller

---
 rtl/sd_cmd_controller.sv | 201 ++++++++++++++++++++
 tb/tb_sd_cmd_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_controller.sv
// ============================================================================
// sd_cmd_controller: issues one SPI-mode SD command frame and collects the
// R1 response, with optional 4 trailing bytes.  Rev 1.0
// ============================================================================
`default_nettype none

module sd_cmd_controller #(
   parameter int MAX_POLL = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_start,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic [6:0]  cmd_crc,
   input  logic        resp_long,
   output logic        tx_start,
   output logic [7:0]  tx_byte,
   input  logic        tx_done,
   output logic        rx_start,
   input  logic [7:0]  rx_byte,
   input  logic        rx_done,
   output logic        cs_n,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [7:0]  r1,
   output logic [31:0] resp_data
);

   localparam int PW = $clog2(MAX_POLL) + 1;
   localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLL - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEND   = 3'd1,
      POLL   = 3'd2,
      EXTRA  = 3'd3,
      FINISH = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [2:0]     byte_cnt_q, byte_cnt_d;
   logic [PW-1:0]  poll_cnt_q, poll_cnt_d;
   logic [31:0]    arg_q, arg_d;
   logic [6:0]     crc_q, crc_d;
   logic           long_q, long_d;
   logic           tx_start_q, tx_start_d;
   logic           rx_start_q, rx_start_d;
   logic [7:0]     tx_byte_q, tx_byte_d;
   logic           cs_n_q, cs_n_d;
   logic           done_q, done_d;
   logic           timeout_q, timeout_d;
   logic [7:0]     r1_q, r1_d;
   logic [31:0]    resp_data_q, resp_data_d;
   logic [2:0]     next_cnt;

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      poll_cnt_d  = poll_cnt_q;
      arg_d       = arg_q;
      crc_d       = crc_q;
      long_d      = long_q;
      tx_start_d  = 1'b0;
      rx_start_d  = 1'b0;
      tx_byte_d   = tx_byte_q;
      cs_n_d      = cs_n_q;
      done_d      = 1'b0;
      timeout_d   = timeout_q;
      r1_d        = r1_q;
      resp_data_d = resp_data_q;
      next_cnt    = byte_cnt_q + 3'd1;

      case (state_q)
         IDLE: begin
            if (cmd_start) begin
               arg_d       = cmd_arg;
               crc_d       = cmd_crc;
               long_d      = resp_long;
               r1_d        = 8'h00;
               resp_data_d = 32'h0;
               timeout_d   = 1'b0;
               cs_n_d      = 1'b0;
               byte_cnt_d  = 3'd0;
               poll_cnt_d  = '0;
               tx_byte_d   = {2'b01, cmd_index};
               tx_start_d  = 1'b1;
               state_d     = SEND;
            end
         end
         SEND: begin
            if (tx_done) begin
               if (byte_cnt_q == 3'd5) begin
                  byte_cnt_d = 3'd0;
                  tx_byte_d  = 8'hFF;
                  rx_start_d = 1'b1;
                  state_d    = POLL;
               end else begin
                  byte_cnt_d = next_cnt;
                  tx_start_d = 1'b1;
                  case (next_cnt)
                     3'd1:    tx_byte_d = arg_q[31:24];
                     3'd2:    tx_byte_d = arg_q[23:16];
                     3'd3:    tx_byte_d = arg_q[15:8];
                     3'd4:    tx_byte_d = arg_q[7:0];
                     default: tx_byte_d = {crc_q, 1'b1};
                  endcase
               end
            end
         end
         POLL: begin
            if (rx_done) begin
               if (!rx_byte[7]) begin
                  r1_d = rx_byte;
                  if (long_q) begin
                     rx_start_d = 1'b1;
                     state_d    = EXTRA;
                  end else begin
                     done_d  = 1'b1;
                     cs_n_d  = 1'b1;
                     state_d = FINISH;
                  end
               end else begin
                  poll_cnt_d = poll_cnt_q + PW'(1);
                  if (poll_cnt_q == POLL_LAST) begin
                     timeout_d = 1'b1;
                     done_d    = 1'b1;
                     cs_n_d    = 1'b1;
                     state_d   = FINISH;
                  end else begin
                     rx_start_d = 1'b1;
                  end
               end
            end
         end
         EXTRA: begin
            if (rx_done) begin
               resp_data_d = {resp_data_q[23:0], rx_byte};
               if (byte_cnt_q == 3'd3) begin
                  done_d  = 1'b1;
                  cs_n_d  = 1'b1;
                  state_d = FINISH;
               end else begin
                  byte_cnt_d = next_cnt;
                  rx_start_d = 1'b1;
               end
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         byte_cnt_q  <= 3'd0;
         poll_cnt_q  <= '0;
         arg_q       <= 32'h0;
         crc_q       <= 7'h0;
         long_q      <= 1'b0;
         tx_start_q  <= 1'b0;
         rx_start_q  <= 1'b0;
         tx_byte_q   <= 8'hFF;
         cs_n_q      <= 1'b1;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         r1_q        <= 8'h00;
         resp_data_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         poll_cnt_q  <= poll_cnt_d;
         arg_q       <= arg_d;
         crc_q       <= crc_d;
         long_q      <= long_d;
         tx_start_q  <= tx_start_d;
         rx_start_q  <= rx_start_d;
         tx_byte_q   <= tx_byte_d;
         cs_n_q      <= cs_n_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         r1_q        <= r1_d;
         resp_data_q <= resp_data_d;
      end
   end

   assign tx_start  = tx_start_q;
   assign tx_byte   = tx_byte_q;
   assign rx_start  = rx_start_q;
   assign cs_n      = cs_n_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign timeout   = timeout_q;
   assign r1        = r1_q;
   assign resp_data = resp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_sd_cmd_controller.sv
// ============================================================================
// tb_sd_cmd_controller: randomized bench with a frame/response reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sd_cmd_controller;

   localparam int MAX_POLL = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_start;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [6:0]  cmd_crc;
   logic        resp_long;
   logic        tx_start;
   logic [7:0]  tx_byte;
   logic        tx_done;
   logic        rx_start;
   logic [7:0]  rx_byte;
   logic        rx_done;
   logic        cs_n;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [7:0]  r1;
   logic [31:0] resp_data;

   int n_tests = 0;
   int n_fail  = 0;

   sd_cmd_controller #(.MAX_POLL(MAX_POLL)) dut (
      .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_index(cmd_index),
      .cmd_arg(cmd_arg), .cmd_crc(cmd_crc), .resp_long(resp_long),
      .tx_start(tx_start), .tx_byte(tx_byte), .tx_done(tx_done),
      .rx_start(rx_start), .rx_byte(rx_byte), .rx_done(rx_done),
      .cs_n(cs_n), .busy(busy), .done(done), .timeout(timeout),
      .r1(r1), .resp_data(resp_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // nff = number of busy (bit7=1) bytes the card returns before R1;
   // nff >= MAX_POLL means R1 never arrives. abort_after > 0 resets the DUT
   // right after that many tx_done pulses.
   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [6:0] crc, input logic lng, input int nff,
                          input logic [7:0] r1v, input logic [31:0] ext,
                          input bit mid_start, input bit spurious, input int abort_after);
      logic [7:0] exp_tx[6];
      logic [7:0] resp[$];
      logic [7:0] got_tx[$];
      int  tx_cnt = 0, rx_cnt = 0, txd = 0, tx_wait = 0, rx_wait = 0, exp_rx, nb;
      bit  tx_pend = 0, rx_pend = 0, got_done = 0, did_mid = 0, did_sp = 0, timed_out, saw_done;
      logic [7:0]  exp_r1;
      logic [31:0] exp_resp;

      exp_tx[0] = {2'b01, idx};
      for (int k = 0; k < 4; k++) exp_tx[k+1] = arg[31-8*k -: 8];
      exp_tx[5] = {crc, 1'b1};

      timed_out = (nff >= MAX_POLL);
      nb = timed_out ? MAX_POLL : nff;
      for (int i = 0; i < nb; i++) resp.push_back(8'h80 | 8'($urandom_range(0, 127)));
      if (!timed_out) begin
         resp.push_back(r1v);
         if (lng) for (int k = 0; k < 4; k++) resp.push_back(ext[31-8*k -: 8]);
      end
      exp_rx   = timed_out ? MAX_POLL : nff + 1 + (lng ? 4 : 0);
      exp_r1   = timed_out ? 8'h00 : r1v;
      exp_resp = (!timed_out && lng) ? ext : 32'h0;

      @(negedge clk);
      cmd_index = idx; cmd_arg = arg; cmd_crc = crc; resp_long = lng; cmd_start = 1'b1;

      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         cmd_start = 1'b0; tx_done = 1'b0; rx_done = 1'b0;
         if (done) begin
            got_done = 1;
            check("cs_n_at_done", cs_n, 1'b1);
            check("timeout", timeout, timed_out);
            check("r1", r1, exp_r1);
            check("resp_data", resp_data, exp_resp);
            break;
         end
         if (tx_start) begin
            if (tx_pend) check("tx_overlap", 1, 0);
            if (tx_cnt == 0) check("cs_n_low", cs_n, 1'b0);
            got_tx.push_back(tx_byte);
            tx_cnt++; tx_pend = 1; tx_wait = $urandom_range(0, 3);
         end else if (tx_pend) begin
            if (tx_byte !== got_tx[got_tx.size()-1]) check("tx_byte_stable", tx_byte, got_tx[got_tx.size()-1]);
            if (tx_wait == 0) begin tx_done = 1'b1; tx_pend = 0; txd++; end
            else tx_wait--;
         end
         if (rx_start) begin
            if (rx_pend) check("rx_overlap", 1, 0);
            rx_cnt++; rx_pend = 1; rx_wait = $urandom_range(0, 3);
         end else if (rx_pend) begin
            if (rx_wait == 0) begin
               rx_done = 1'b1; rx_pend = 0;
               rx_byte = (rx_cnt - 1 < resp.size()) ? resp[rx_cnt-1] : 8'hFF;
            end else rx_wait--;
         end
         if (mid_start && !did_mid && tx_cnt == 2) begin
            cmd_start = 1'b1; did_mid = 1;
            cmd_index = 6'($urandom); cmd_arg = $urandom; cmd_crc = 7'($urandom); resp_long = ~lng;
         end
         if (spurious && !did_sp && tx_cnt == 3 && !rx_pend) begin
            rx_done = 1'b1; rx_byte = 8'h00; did_sp = 1;
         end
         if (abort_after > 0 && txd == abort_after) break;
      end

      if (abort_after > 0) begin
         @(negedge clk);
         tx_done = 1'b0; rx_done = 1'b0; reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         check("abort_busy", busy, 1'b0);
         check("abort_cs_n", cs_n, 1'b1);
         check("abort_done", done, 1'b0);
         check("abort_tx_start", tx_start, 1'b0);
         check("abort_tx_byte", tx_byte, 8'hFF);
         saw_done = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || tx_start || rx_start) saw_done = 1;
         end
         check("abort_quiet", saw_done, 1'b0);
         return;
      end

      check("done_seen", got_done, 1'b1);
      check("tx_count", tx_cnt, 6);
      for (int k = 0; k < got_tx.size() && k < 6; k++) check($sformatf("tx_byte%0d", k), got_tx[k], exp_tx[k]);
      check("rx_count", rx_cnt, exp_rx);
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_cs_n", cs_n, 1'b1);
      check("idle_done", done, 1'b0);
      check("r1_held", r1, exp_r1);
      check("resp_held", resp_data, exp_resp);
   endtask

   initial begin
      reset = 1'b1; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; cmd_crc = '0;
      resp_long = 1'b0; tx_done = 1'b0; rx_done = 1'b0; rx_byte = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_cs_n", cs_n, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_timeout", timeout, 1'b0);
      check("rst_tx_start", tx_start, 1'b0);
      check("rst_rx_start", rx_start, 1'b0);
      check("rst_tx_byte", tx_byte, 8'hFF);
      check("rst_r1", r1, 8'h00);
      check("rst_resp", resp_data, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // CMD0, CMD8, all-busy timeout
      run_cmd(6'd0, 32'h0, 7'h4A, 1'b0, 1, 8'h01, 32'h0, 0, 0, 0);
      run_cmd(6'd8, 32'h000001AA, 7'h43, 1'b1, 0, 8'h01, 32'h000001AA, 0, 0, 0);
      run_cmd(6'd1, 32'h0, 7'h7C, 1'b0, MAX_POLL, 8'h00, 32'h0, 0, 0, 0);
      // R1 on the last permitted poll
      run_cmd(6'd55, 32'h0, 7'h32, 1'b0, MAX_POLL - 1, 8'h00, 32'h0, 0, 0, 0);
      // cmd_start ignored during SEND, spurious rx_done during SEND
      run_cmd(6'd17, 32'h12345678, 7'h11, 1'b0, 2, 8'h00, 32'h0, 1, 0, 0);
      run_cmd(6'd58, 32'hCAFEF00D, 7'h22, 1'b1, 1, 8'h01, 32'hDEADBEEF, 0, 1, 0);
      // reset after third tx_done, then a normal command
      run_cmd(6'd9, 32'hA5A5A5A5, 7'h0F, 1'b0, 0, 8'h00, 32'h0, 0, 0, 3);
      run_cmd(6'd0, 32'h0, 7'h4A, 1'b0, 1, 8'h01, 32'h0, 0, 0, 0);

      for (int t = 0; t < 25; t++) begin
         run_cmd(6'($urandom), $urandom, 7'($urandom), 1'($urandom),
                 $urandom_range(0, MAX_POLL + 1), 8'($urandom_range(0, 127)), $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
